// File: rtl/spi_rx_deserializer_if.sv
// spi_rx_deserializer_if
//   Groups the receive stage's signals so the deserializer sees one port.
//   The master modport is the surrounding SPI master (serializer timing,
//   baud generator and Avalon register block); the slave modport is the
//   deserializer itself.
//   Control/serial side : enable, frame, baud_out, rx, word_size, busy
//   Register side       : rd, ov_clear, data_out, rxfe, rxff, rxfo, level
interface spi_rx_deserializer_if #(
  parameter int N = 16,
  parameter int M = 32
);
  localparam int AW = $clog2(N);

  logic          enable;
  logic          frame;
  logic          baud_out;
  logic          rx;
  logic [4:0]    word_size;
  logic          rd;
  logic          ov_clear;
  logic [M-1:0]  data_out;
  logic          rxfe;
  logic          rxff;
  logic          rxfo;
  logic [AW:0]   level;
  logic          busy;

  modport master (
    output enable, frame, baud_out, rx, word_size, rd, ov_clear,
    input  data_out, rxfe, rxff, rxfo, level, busy
  );

  modport slave (
    input  enable, frame, baud_out, rx, word_size, rd, ov_clear,
    output data_out, rxfe, rxff, rxfo, level, busy
  );
endinterface

// File: rtl/spi_rx_deserializer.sv
// spi_rx_deserializer
//   Receive side of the SPI master. Samples rx on each falling edge of the
//   bit clock while frame is high, assembles MSB-first words of word_size
//   bits and stores them right-justified in an N-deep RX FIFO that the
//   register block drains through rd.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high, clears all state
//   bus    : spi_rx_deserializer_if.slave (serial inputs, FIFO read port,
//            status flags, busy)
module spi_rx_deserializer #(
  parameter int N = 16,
  parameter int M = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  spi_rx_deserializer_if.slave   bus
);
  localparam int AW = $clog2(N);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(N);

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

  state_t        state;
  logic          rx_sync_p0, rx_sync_p1;
  logic          baud_q_p0;
  logic [4:0]    bits_left;
  logic [M-1:0]  shift;
  logic          busy_q;

  logic [M-1:0]  mem [N];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   level;
  logic          rxfo_q;

  logic          fall, run, empty, full;
  logic          push, do_pop, do_push, overflow;

  // Stage p0/p1: rx synchronizer and bit-clock edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_p0 <= 1'b0;
      rx_sync_p1 <= 1'b0;
      baud_q_p0  <= 1'b0;
    end else begin
      rx_sync_p0 <= bus.rx;
      rx_sync_p1 <= rx_sync_p0;
      baud_q_p0  <= bus.baud_out;
    end
  end

  assign fall = baud_q_p0 & ~bus.baud_out;
  assign run  = bus.enable & bus.frame;

  // Word assembly; an abort (frame or enable low) outranks a pending sample
  // so a truncated word is never pushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bits_left <= '0;
      shift     <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run && bus.word_size != 5'd0) begin
            bits_left <= bus.word_size;
            shift     <= '0;
            state     <= SHIFT;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (!run) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (fall) begin
            shift     <= {shift[M-2:0], rx_sync_p1};
            bits_left <= bits_left - 5'd1;
            if (bits_left == 5'd1) state <= PUSH;
          end
        end
        PUSH: begin
          // word_size is rechecked so a zero size never enters SHIFT with
          // nothing to count down.
          if (run && bus.word_size != 5'd0) begin
            bits_left <= bus.word_size;
            shift     <= '0;
            state     <= SHIFT;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign empty    = (level == '0);
  assign full     = (level == LVL_FULL);
  assign push     = (state == PUSH);
  assign do_pop   = bus.rd & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;

  // Stage p2: FIFO storage and bookkeeping
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp     <= '0;
      rp     <= '0;
      level  <= '0;
      rxfo_q <= 1'b0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (overflow)          rxfo_q <= 1'b1;
      else if (bus.ov_clear) rxfo_q <= 1'b0;
    end
  end

  assign bus.data_out = empty ? '0 : mem[rp];
  assign bus.rxfe     = empty;
  assign bus.rxff     = full;
  assign bus.rxfo     = rxfo_q;
  assign bus.level    = level;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_spi_rx_deserializer.sv
// tb_spi_rx_deserializer
//   Bench for spi_rx_deserializer (N=16, M=32). A queue model of the FIFO is
//   fed by the stimulus driver, which knows each word it sends and the cycle
//   at which that word must land; the model is compared with the DUT flags,
//   level and head word every cycle, and directed literal checks pin it.
module tb_spi_rx_deserializer;
  localparam int N = 16;
  localparam int M = 32;

  typedef struct {
    logic [31:0] w;
    int unsigned e;
  } pend_t;

  logic clk;
  logic reset;

  spi_rx_deserializer_if #(.N(N), .M(M)) bus();

  spi_rx_deserializer #(.N(N), .M(M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned edge_n = 0;
  bit          chk_en = 1'b0;
  bit          rand_done = 1'b0;

  logic [31:0] mq [$];
  pend_t       pend [$];
  logic        m_rxfo = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: applies the pushes and pops that take effect at each edge.
  always @(posedge clk) begin
    pend_t p;
    bit popping, ovf;
    edge_n++;
    if (!reset) begin
      ovf = 1'b0;
      popping = bus.rd && (mq.size() > 0);
      if (popping) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].e == edge_n) begin
        p = pend.pop_front();
        if (mq.size() < N) mq.push_back(p.w);
        else ovf = 1'b1;
      end
      if (ovf) m_rxfo = 1'b1;
      else if (bus.ov_clear) m_rxfo = 1'b0;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      pend.delete();
      m_rxfo = 1'b0;
    end
    if (chk_en) begin
      check("data_out", bus.data_out, (mq.size() > 0) ? mq[0] : 32'h0);
      check("rxfe", 32'(bus.rxfe), 32'(mq.size() == 0));
      check("rxff", 32'(bus.rxff), 32'(mq.size() == N));
      check("rxfo", 32'(bus.rxfo), 32'(m_rxfo));
      check("level", 32'(bus.level), 32'(mq.size()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word MSB-first: rx set with the bit clock's rising half, sampled
  // at its fall. stop_after >= 0 stops after that many bits (no push).
  // mode 1: latency probe on an empty FIFO; mode 2: rd in the write cycle.
  task automatic send_word(input logic [31:0] w, input int nb, input int h,
                           input int stop_after, input int mode);
    logic [31:0] mask;
    mask = (32'h1 << nb) - 32'h1;
    for (int i = nb - 1; i >= 0; i--) begin
      if (nb - 1 - i == stop_after) return;
      bus.rx = w[i];
      bus.baud_out = 1'b1;
      repeat (h) tick();
      bus.baud_out = 1'b0;
      if (i == 0) begin
        pend.push_back('{w: w & mask, e: edge_n + 2});
        if (mode == 1) begin
          tick();
          check("lat_rxfe_pre", 32'(bus.rxfe), 32'h1);
          tick();
          check("lat_rxfe_post", 32'(bus.rxfe), 32'h0);
          check("lat_data", bus.data_out, w & mask);
          check("lat_level", 32'(bus.level), 32'h1);
          repeat (h - 2) tick();
        end else if (mode == 2) begin
          tick();
          bus.rd = 1'b1;
          tick();
          bus.rd = 1'b0;
          check("fullrw_level", 32'(bus.level), 32'd16);
          check("fullrw_rxfo", 32'(bus.rxfo), 32'h0);
          repeat (h - 2) tick();
        end else begin
          repeat (h) tick();
        end
      end else begin
        repeat (h) tick();
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < N + 1; k++) begin
      if (bus.rxfe) break;
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
    end
    check("drain_empty", 32'(bus.rxfe), 32'h1);
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.frame = 1'b0;
    bus.baud_out = 1'b0;
    bus.rx = 1'b0;
    bus.word_size = 5'd8;
    bus.rd = 1'b0;
    bus.ov_clear = 1'b0;
    repeat (3) tick();
    check("rst_data", bus.data_out, 32'h0);
    check("rst_rxfe", 32'(bus.rxfe), 32'h1);
    check("rst_rxff", 32'(bus.rxff), 32'h0);
    check("rst_rxfo", 32'(bus.rxfo), 32'h0);
    check("rst_level", 32'(bus.level), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // Single 8-bit word with latency probe
    bus.frame = 1'b1;
    tick();
    send_word(32'hA5, 8, 4, -1, 1);
    bus.frame = 1'b0;
    tick();
    check("a5_data", bus.data_out, 32'h0000_00A5);
    drain();

    // 32 back-to-back words into a 16-deep FIFO
    bus.frame = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) send_word(32'(i), 8, 4, -1, 0);
    bus.frame = 1'b0;
    tick();
    check("ovf_level", 32'(bus.level), 32'd16);
    check("ovf_rxff", 32'(bus.rxff), 32'h1);
    check("ovf_rxfo", 32'(bus.rxfo), 32'h1);
    for (int i = 0; i < 16; i++) begin
      check("ovf_order", bus.data_out, 32'(i));
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
    end
    check("ovf_drained", 32'(bus.rxfe), 32'h1);
    check("ovf_sticky", 32'(bus.rxfo), 32'h1);
    bus.ov_clear = 1'b1;
    tick();
    bus.ov_clear = 1'b0;
    check("ovf_cleared", 32'(bus.rxfo), 32'h0);

    // Frame dropped after 5 of 8 bits, then a good word
    bus.frame = 1'b1;
    tick();
    send_word(32'hC3, 8, 4, 5, 0);
    check("abort_busy_pre", 32'(bus.busy), 32'h1);
    bus.frame = 1'b0;
    tick();
    check("abort_busy_post", 32'(bus.busy), 32'h0);
    check("abort_level", 32'(bus.level), 32'h0);
    bus.frame = 1'b1;
    tick();
    send_word(32'h3C, 8, 4, -1, 0);
    bus.frame = 1'b0;
    tick();
    check("after_abort_data", bus.data_out, 32'h3C);
    drain();

    // Full FIFO with push and rd in the same cycle
    bus.frame = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) send_word(32'h40 + 32'(i), 8, 4, -1, 0);
    send_word(32'h50, 8, 4, -1, 2);
    bus.frame = 1'b0;
    tick();
    check("fullrw_head", bus.data_out, 32'h41);
    drain();

    // 31-bit word
    bus.word_size = 5'd31;
    bus.frame = 1'b1;
    tick();
    send_word(32'h5555_AAAA, 31, 4, -1, 0);
    bus.frame = 1'b0;
    tick();
    check("ws31_data", bus.data_out, 32'h5555_AAAA);
    check("ws31_msb", 32'(bus.data_out[31]), 32'h0);
    drain();

    // Asynchronous reset mid-word with 3 words stored
    bus.word_size = 5'd8;
    bus.frame = 1'b1;
    tick();
    send_word(32'h11, 8, 4, -1, 0);
    send_word(32'h22, 8, 4, -1, 0);
    send_word(32'h33, 8, 4, -1, 0);
    send_word(32'h44, 8, 4, 3, 0);
    check("pre_rst_level", 32'(bus.level), 32'd3);
    check("pre_rst_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    #1;
    check("arst_data", bus.data_out, 32'h0);
    check("arst_rxfe", 32'(bus.rxfe), 32'h1);
    check("arst_rxff", 32'(bus.rxff), 32'h0);
    check("arst_rxfo", 32'(bus.rxfo), 32'h0);
    check("arst_level", 32'(bus.level), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    bus.frame = 1'b0;
    bus.baud_out = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    bus.frame = 1'b1;
    tick();
    send_word(32'hFF, 8, 4, -1, 0);
    bus.frame = 1'b0;
    tick();
    check("post_rst_data", bus.data_out, 32'hFF);
    check("post_rst_level", 32'(bus.level), 32'h1);
    drain();

    // Randomized frames with concurrent reads and overflow clears
    fork
      begin
        for (int f = 0; f < 12; f++) begin
          int ws, nw, h, ab;
          ws = $urandom_range(31, 1);
          nw = $urandom_range(3, 1);
          h  = $urandom_range(5, 4);
          ab = ($urandom_range(3, 0) == 0) ? $urandom_range(ws - 1, 0) : -1;
          bus.word_size = 5'(ws);
          tick();
          bus.frame = 1'b1;
          tick();
          for (int j = 0; j < nw; j++)
            send_word($urandom(), ws, h, (j == nw - 1) ? ab : -1, 0);
          bus.frame = 1'b0;
          repeat (3) tick();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          bus.rd = ($urandom_range(3, 0) == 0);
          bus.ov_clear = ($urandom_range(15, 0) == 0);
          tick();
        end
        bus.rd = 1'b0;
        bus.ov_clear = 1'b0;
      end
    join
    tick();
    drain();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
